// File: rtl/wb_pkg.sv
// Shared defaults and types for the writeback queue.
package wb_pkg;

  localparam int unsigned DataWDef = 32;
  localparam int unsigned AddrWDef = 5;

  // Register x0 is hardwired to zero; writes to it are dropped.
  localparam int unsigned RegX0 = 0;

  typedef struct packed {
    logic [AddrWDef-1:0] rd;
    logic [DataWDef-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular result buffer for the writeback queue. Exposes every slot and its
// valid bit so the parent can search for in-flight destination registers.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = DataWDef,
  parameter int unsigned ADDR_W = AddrWDef
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [ADDR_W-1:0]        push_rd,
  input  logic [DATA_W-1:0]        push_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH)-1:0] tail,
  output logic [ADDR_W-1:0]        head_rd,
  output logic [DATA_W-1:0]        head_data,
  output logic [DEPTH-1:0]         ent_valid,
  output logic [ADDR_W-1:0]        ent_rd   [DEPTH],
  output logic [DATA_W-1:0]        ent_data [DEPTH]
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] rd_q    [DEPTH];
  logic [DATA_W-1:0] data_q  [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [PtrW-1:0]   head_q, tail_q;
  logic [CntW-1:0]   count_q;
  logic              push_en, pop_en;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  // Guard against overflow/underflow even if the parent misbehaves.
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;

  // Pointer, occupancy and per-slot valid bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      if (push_en) begin
        tail_q          <= tail_q + PtrW'(1);
        valid_q[tail_q] <= 1'b1;
      end
      if (pop_en) begin
        head_q          <= head_q + PtrW'(1);
        valid_q[head_q] <= 1'b0;
      end
      if (push_en && !pop_en) begin
        count_q <= count_q + CntW'(1);
      end else if (pop_en && !push_en) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  // Entry payload storage; validity is tracked separately so no reset needed.
  always_ff @(posedge clk) begin
    if (push_en) begin
      rd_q[tail_q]   <= push_rd;
      data_q[tail_q] <= push_data;
    end
  end

  assign tail      = tail_q;
  assign head_rd   = rd_q[head_q];
  assign head_data = data_q[head_q];
  assign ent_valid = valid_q;
  assign ent_rd    = rd_q;
  assign ent_data  = data_q;

endmodule

// File: rtl/writeback_queue.sv
// Writeback queue: buffers results and drains one per cycle into the register
// file write port, yielding to an external writer. Reports in-flight writes to
// decode. Define WRITEBACK_BYPASS_EN to also forward the youngest value.
module writeback_queue
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = DataWDef,
  parameter int unsigned ADDR_W = AddrWDef
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [DATA_W-1:0] in_data,
  input  logic              ext_wr_req,
  input  logic [ADDR_W-1:0] ext_rd,
  input  logic [DATA_W-1:0] ext_data,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] rd,
  output logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic              rs1_pending,
  output logic              rs2_pending,
  output logic              rs1_fwd_valid,
  output logic              rs2_fwd_valid,
  output logic [DATA_W-1:0] rs1_fwd_data,
  output logic [DATA_W-1:0] rs2_fwd_data
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic                full, empty, push, pop;
  logic [PtrW-1:0]     tail;
  logic [ADDR_W-1:0]   head_rd;
  logic [DATA_W-1:0]   head_data;
  logic [DEPTH-1:0]    ent_valid;
  logic [ADDR_W-1:0]   ent_rd   [DEPTH];
  logic [DATA_W-1:0]   ent_data [DEPTH];

  logic                reg_write_q;
  logic [ADDR_W-1:0]   rd_q;
  logic [DATA_W-1:0]   write_data_q;
  logic                rs1_q_hit, rs2_q_hit;

  // Ready reads high during reset; the fifo's own reset discards the push.
  assign in_ready = rst || !full;
  // x0 results complete the handshake but are never stored.
  assign push     = in_valid && !full && (in_rd != ADDR_W'(RegX0));
  assign pop      = !ext_wr_req && !empty;

  wb_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_rd   (in_rd),
    .push_data (in_data),
    .full      (full),
    .empty     (empty),
    .tail      (tail),
    .head_rd   (head_rd),
    .head_data (head_data),
    .ent_valid (ent_valid),
    .ent_rd    (ent_rd),
    .ent_data  (ent_data)
  );

  // Output register: external writer first, then queue head, else idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write_q  <= 1'b0;
      rd_q         <= '0;
      write_data_q <= '0;
    end else if (ext_wr_req) begin
      reg_write_q  <= (ext_rd != ADDR_W'(RegX0));
      rd_q         <= ext_rd;
      write_data_q <= ext_data;
    end else if (!empty) begin
      reg_write_q  <= 1'b1;
      rd_q         <= head_rd;
      write_data_q <= head_data;
    end else begin
      reg_write_q  <= 1'b0;
    end
  end

  assign RegWrite   = reg_write_q;
  assign rd         = rd_q;
  assign write_data = write_data_q;

  // Search every valid queue slot for the decode source registers.
  always_comb begin
    rs1_q_hit = 1'b0;
    rs2_q_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (ent_rd[i] == rs1)) rs1_q_hit = 1'b1;
      if (ent_valid[i] && (ent_rd[i] == rs2)) rs2_q_hit = 1'b1;
    end
  end

  // The output register still counts: register_file commits one edge later.
  assign rs1_pending = (rs1 != ADDR_W'(RegX0)) &&
                       (rs1_q_hit || (reg_write_q && (rd_q == rs1)));
  assign rs2_pending = (rs2 != ADDR_W'(RegX0)) &&
                       (rs2_q_hit || (reg_write_q && (rd_q == rs2)));

`ifdef WRITEBACK_BYPASS_EN
  logic            rs1_fwd_hit, rs2_fwd_hit;
  logic [PtrW-1:0] idx;

  // Walk from newest slot backwards; output register is the oldest fallback.
  always_comb begin
    rs1_fwd_data = write_data_q;
    rs2_fwd_data = write_data_q;
    rs1_fwd_hit  = 1'b0;
    rs2_fwd_hit  = 1'b0;
    idx          = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = tail - PtrW'(k) - PtrW'(1);
      if (!rs1_fwd_hit && ent_valid[idx] && (ent_rd[idx] == rs1)) begin
        rs1_fwd_hit  = 1'b1;
        rs1_fwd_data = ent_data[idx];
      end
      if (!rs2_fwd_hit && ent_valid[idx] && (ent_rd[idx] == rs2)) begin
        rs2_fwd_hit  = 1'b1;
        rs2_fwd_data = ent_data[idx];
      end
    end
  end

  assign rs1_fwd_valid = rs1_pending;
  assign rs2_fwd_valid = rs2_pending;
`else
  logic unused_fwd;

  // Forwarding is compiled out; fold the slot data so it is visibly consumed.
  always_comb begin
    unused_fwd = ^tail;
    for (int k = 0; k < DEPTH; k++) begin
      unused_fwd = unused_fwd ^ (^ent_data[k]);
    end
  end

  assign rs1_fwd_valid = 1'b0;
  assign rs2_fwd_valid = 1'b0;
  assign rs1_fwd_data  = '0;
  assign rs2_fwd_data  = '0;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Bench for writeback_queue: directed vector table, a forwarding sequence and
// randomized traffic against a queue-based reference model.
module tb_writeback_queue;
  import wb_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        rst, in_valid, in_ready, ext_wr_req, RegWrite;
  logic [4:0]  in_rd, ext_rd, rd, rs1, rs2;
  logic [31:0] in_data, ext_data, write_data;
  logic        rs1_pending, rs2_pending, rs1_fwd_valid, rs2_fwd_valid;
  logic [31:0] rs1_fwd_data, rs2_fwd_data;

  int n_cmp = 0;
  int n_err = 0;

  writeback_queue #(
    .DEPTH  (DEPTH),
    .DATA_W (32),
    .ADDR_W (5)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_rd         (in_rd),
    .in_data       (in_data),
    .ext_wr_req    (ext_wr_req),
    .ext_rd        (ext_rd),
    .ext_data      (ext_data),
    .RegWrite      (RegWrite),
    .rd            (rd),
    .write_data    (write_data),
    .rs1           (rs1),
    .rs2           (rs2),
    .rs1_pending   (rs1_pending),
    .rs2_pending   (rs2_pending),
    .rs1_fwd_valid (rs1_fwd_valid),
    .rs2_fwd_valid (rs2_fwd_valid),
    .rs1_fwd_data  (rs1_fwd_data),
    .rs2_fwd_data  (rs2_fwd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst, iv;
    logic [4:0]  ird;
    logic [31:0] idat;
    logic        ext;
    logic [4:0]  erd;
    logic [31:0] edat;
    logic [4:0]  r1, r2;
    logic        e_rdy, e_p1, e_p2, e_rw;
    logic [4:0]  e_rd;
    logic [31:0] e_wd;
  } vec_t;

  function automatic vec_t mk(input int unsigned r, iv, ird, idat, ext, erd, edat, r1, r2,
                              rdy, p1, p2, rw, ord, owd);
    vec_t v;
    v.rst = 1'(r);   v.iv = 1'(iv);   v.ird = 5'(ird);  v.idat = idat;
    v.ext = 1'(ext); v.erd = 5'(erd); v.edat = edat;
    v.r1 = 5'(r1);   v.r2 = 5'(r2);
    v.e_rdy = 1'(rdy); v.e_p1 = 1'(p1); v.e_p2 = 1'(p2);
    v.e_rw = 1'(rw);   v.e_rd = 5'(ord); v.e_wd = owd;
    return v;
  endfunction

  task automatic drive(input logic r, iv, input logic [4:0] ird, input logic [31:0] idat,
                       input logic ext, input logic [4:0] erd, input logic [31:0] edat,
                       input logic [4:0] r1, r2);
    rst = r; in_valid = iv; in_rd = ird; in_data = idat;
    ext_wr_req = ext; ext_rd = erd; ext_data = edat; rs1 = r1; rs2 = r2;
  endtask

  // Reference model state
  wb_entry_t   mq[$];
  logic        m_rw;
  logic [4:0]  m_rd;
  logic [31:0] m_wd;

  function automatic logic m_pend(input logic [4:0] rs);
    if (rs == 5'd0) return 1'b0;
    foreach (mq[i]) if (mq[i].rd == rs) return 1'b1;
    return m_rw && (m_rd == rs);
  endfunction

  function automatic logic [31:0] m_fwd(input logic [4:0] rs);
    for (int i = mq.size() - 1; i >= 0; i--) if (mq[i].rd == rs) return mq[i].data;
    return m_wd;
  endfunction

  task automatic m_edge();
    wb_entry_t e;
    logic acc;
    if (rst) begin
      mq.delete();
      m_rw = 1'b0; m_rd = '0; m_wd = '0;
    end else begin
      acc = in_valid && (mq.size() < DEPTH);
      if (ext_wr_req) begin
        m_rw = (ext_rd != 5'd0); m_rd = ext_rd; m_wd = ext_data;
      end else if (mq.size() > 0) begin
        e = mq.pop_front();
        m_rw = 1'b1; m_rd = e.rd; m_wd = e.data;
      end else begin
        m_rw = 1'b0;
      end
      if (acc && in_rd != 5'd0) begin
        e.rd = in_rd; e.data = in_data;
        mq.push_back(e);
      end
    end
  endtask

  vec_t vt[28];
  logic p;

  initial begin
    drive(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, '0, '0);
    vt[0]  = mk(1, 0, 0, 0,          0, 0, 0,    0,  0,  1, 0, 0, 0, 0,  0);
    vt[1]  = mk(0, 1, 5, 32'hA5A5A5A5, 0, 0, 0,  5,  0,  1, 0, 0, 0, 0,  0);
    vt[2]  = mk(0, 0, 0, 0,          0, 0, 0,    5,  0,  1, 1, 0, 1, 5,  32'hA5A5A5A5);
    vt[3]  = mk(0, 0, 0, 0,          0, 0, 0,    5,  0,  1, 1, 0, 0, 5,  32'hA5A5A5A5);
    vt[4]  = mk(0, 0, 0, 0,          0, 0, 0,    5,  0,  1, 0, 0, 0, 5,  32'hA5A5A5A5);
    vt[5]  = mk(0, 1, 0, 32'hFFFFFFFF, 0, 0, 0,  0,  0,  1, 0, 0, 0, 5,  32'hA5A5A5A5);
    vt[6]  = mk(0, 0, 0, 0,          0, 0, 0,    0,  0,  1, 0, 0, 0, 5,  32'hA5A5A5A5);
    vt[7]  = mk(0, 1, 1, 32'h101,    1, 9, 32'h99, 1, 4, 1, 0, 0, 1, 9,  32'h99);
    vt[8]  = mk(0, 1, 2, 32'h102,    1, 9, 32'h99, 1, 4, 1, 1, 0, 1, 9,  32'h99);
    vt[9]  = mk(0, 1, 3, 32'h103,    1, 9, 32'h99, 1, 4, 1, 1, 0, 1, 9,  32'h99);
    vt[10] = mk(0, 1, 4, 32'h104,    1, 9, 32'h99, 1, 4, 1, 1, 0, 1, 9,  32'h99);
    vt[11] = mk(0, 1, 5, 32'h105,    1, 9, 32'h99, 1, 4, 0, 1, 1, 1, 9,  32'h99);
    vt[12] = mk(0, 1, 6, 32'h106,    1, 9, 32'h99, 1, 4, 0, 1, 1, 1, 9,  32'h99);
    vt[13] = mk(0, 0, 0, 0,          0, 0, 0,    1,  4,  0, 1, 1, 1, 1,  32'h101);
    vt[14] = mk(0, 0, 0, 0,          0, 0, 0,    1,  4,  1, 1, 1, 1, 2,  32'h102);
    vt[15] = mk(0, 0, 0, 0,          0, 0, 0,    1,  4,  1, 0, 1, 1, 3,  32'h103);
    vt[16] = mk(0, 0, 0, 0,          0, 0, 0,    1,  4,  1, 0, 1, 1, 4,  32'h104);
    vt[17] = mk(0, 0, 0, 0,          0, 0, 0,    1,  4,  1, 0, 1, 0, 4,  32'h104);
    vt[18] = mk(0, 0, 0, 0,          0, 0, 0,    1,  4,  1, 0, 0, 0, 4,  32'h104);
    vt[19] = mk(0, 1, 10, 32'h10A,   1, 0, 32'h55, 10, 13, 1, 0, 0, 0, 0, 32'h55);
    vt[20] = mk(0, 1, 11, 32'h10B,   1, 0, 32'h55, 10, 13, 1, 1, 0, 0, 0, 32'h55);
    vt[21] = mk(0, 1, 12, 32'h10C,   1, 0, 32'h55, 10, 13, 1, 1, 0, 0, 0, 32'h55);
    vt[22] = mk(0, 1, 13, 32'h10D,   1, 0, 32'h55, 10, 13, 1, 1, 0, 0, 0, 32'h55);
    vt[23] = mk(0, 1, 14, 32'h10E,   0, 0, 0,    10, 13, 0, 1, 1, 1, 10, 32'h10A);
    vt[24] = mk(0, 0, 0, 0,          0, 0, 0,    14, 13, 1, 0, 1, 1, 11, 32'h10B);
    vt[25] = mk(1, 0, 0, 0,          0, 0, 0,    12, 13, 1, 1, 1, 0, 0,  0);
    vt[26] = mk(0, 0, 0, 0,          0, 0, 0,    12, 13, 1, 0, 0, 0, 0,  0);
    vt[27] = mk(0, 0, 0, 0,          0, 0, 0,    12, 13, 1, 0, 0, 0, 0,  0);

    @(negedge clk);
    for (int i = 0; i < 28; i++) begin
      drive(vt[i].rst, vt[i].iv, vt[i].ird, vt[i].idat, vt[i].ext, vt[i].erd, vt[i].edat,
            vt[i].r1, vt[i].r2);
      #1;
      chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vt[i].e_rdy));
      chk($sformatf("vec%0d rs1_pending", i), 32'(rs1_pending), 32'(vt[i].e_p1));
      chk($sformatf("vec%0d rs2_pending", i), 32'(rs2_pending), 32'(vt[i].e_p2));
      @(posedge clk); #1;
      chk($sformatf("vec%0d RegWrite", i), 32'(RegWrite), 32'(vt[i].e_rw));
      chk($sformatf("vec%0d rd", i), 32'(rd), 32'(vt[i].e_rd));
      chk($sformatf("vec%0d write_data", i), write_data, vt[i].e_wd);
      @(negedge clk);
    end

    // Two writes to x7 held behind an external writer; youngest must win.
    drive(1'b0, 1'b1, 5'd7, 32'h11, 1'b1, 5'd0, 32'h0, 5'd0, 5'd7);
    @(negedge clk);
    drive(1'b0, 1'b1, 5'd7, 32'h22, 1'b1, 5'd0, 32'h0, 5'd0, 5'd7);
    @(negedge clk);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h0, 5'd0, 5'd7);
    #1;
    chk("byp rs2_pending", 32'(rs2_pending), 32'd1);
`ifdef WRITEBACK_BYPASS_EN
    chk("byp rs2_fwd_valid", 32'(rs2_fwd_valid), 32'd1);
    chk("byp rs2_fwd_data", rs2_fwd_data, 32'h22);
`else
    chk("byp rs2_fwd_valid", 32'(rs2_fwd_valid), 32'd0);
    chk("byp rs2_fwd_data", rs2_fwd_data, 32'h0);
`endif
    @(negedge clk);

    // Randomized traffic against the model; first cycle resets both.
    for (int i = 0; i < 2000; i++) begin
      drive((i == 0) || ($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 3) == 0),
            5'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)));
      #1;
      if (i > 0) begin
        chk("rnd in_ready", 32'(in_ready), 32'(rst || (mq.size() < DEPTH)));
        p = m_pend(rs1);
        chk("rnd rs1_pending", 32'(rs1_pending), 32'(p));
`ifdef WRITEBACK_BYPASS_EN
        chk("rnd rs1_fwd_valid", 32'(rs1_fwd_valid), 32'(p));
        if (p) chk("rnd rs1_fwd_data", rs1_fwd_data, m_fwd(rs1));
`else
        chk("rnd rs1_fwd_valid", 32'(rs1_fwd_valid), 32'd0);
`endif
        p = m_pend(rs2);
        chk("rnd rs2_pending", 32'(rs2_pending), 32'(p));
`ifdef WRITEBACK_BYPASS_EN
        chk("rnd rs2_fwd_valid", 32'(rs2_fwd_valid), 32'(p));
        if (p) chk("rnd rs2_fwd_data", rs2_fwd_data, m_fwd(rs2));
`else
        chk("rnd rs2_fwd_data", rs2_fwd_data, 32'd0);
`endif
      end
      @(posedge clk);
      m_edge();
      #1;
      chk("rnd RegWrite", 32'(RegWrite), 32'(m_rw));
      chk("rnd rd", 32'(rd), 32'(m_rd));
      chk("rnd write_data", write_data, m_wd);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/writeback_queue.md
# writeback_queue

Buffers completed instruction results and drains them, one per cycle, into the register file write port (RegWrite/rd/write_data). It sits between the execute/load result producers and register_file, and owns that write port. It arbitrates the port against a higher-priority external writer such as a debug or loader path. For the decode stage it reports whether a source register (rs1/rs2) still has a write in flight, and can optionally forward that value.

## Interface
Parameters:
- DEPTH, 4: queue entries; power of two, at least 2.
- DATA_W, 32: result width.
- ADDR_W, 5: register index width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  producer has a result.
- in_ready  out  1  queue can accept; equals (count != DEPTH).
- in_rd  in  ADDR_W  destination register.
- in_data  in  DATA_W  result value.
- ext_wr_req  in  1  external write; wins the port this cycle.
- ext_rd  in  ADDR_W  external destination.
- ext_data  in  DATA_W  external value.
- RegWrite  out  1  registered write enable to register_file.
- rd  out  ADDR_W  registered destination.
- write_data  out  DATA_W  registered data.
- rs1, rs2  in  ADDR_W  decode-stage source indices.
- rs1_pending, rs2_pending  out  1  a write to that register is queued or on the output.
- rs1_fwd_valid, rs2_fwd_valid  out  1  forwarded value valid (BYPASS_EN only).
- rs1_fwd_data, rs2_fwd_data  out  DATA_W  youngest in-flight value (BYPASS_EN only).

## Operation
- Push: at an edge where in_valid && in_ready && !rst, the entry {in_rd, in_data} is appended at the tail.
  - If in_rd == 0, the handshake still completes, but nothing is enqueued.
- Output stage, evaluated at each edge with rst low:
  - If ext_wr_req: load {1, ext_rd, ext_data}. The queue does not pop. If ext_rd == 0, RegWrite is loaded as 0.
  - Else if count > 0: load {1, head.rd, head.data} and pop the head.
  - Else: RegWrite loads 0. rd and write_data hold their previous values.
- Push and pop on the same edge: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- Full: in_ready = 0, so no push is possible. Pop remains allowed.
- rsN_pending = (rsN != 0) && (rsN matches any valid queue entry, or rsN == rd while RegWrite is high).
  - The output-register match is required because register_file commits at the following edge.
- Pending and forward outputs are combinational from current state. They do not see a push occurring in the same cycle.
- Reset behaviour:
  - Queue flushed; count = 0; head/tail = 0.
  - RegWrite = 0, rd = 0, write_data = 0.
  - rsN_fwd_valid = 0.
  - Reset mid-operation drops all queued entries without writing them.
  - in_ready reads 1 while rst is high, but pushes are ignored.

## Timing
- Handshake accepted at edge E1 → entry is in the queue after E1.
- Earliest output-register load is at E2; register_file writes at E3.
  - This holds when no ext_wr_req is present and the entry is at the head.
- Queue throughput is one drain per cycle. Each ext_wr_req cycle stalls the drain by one cycle.
- rsN_pending rises in the cycle after the handshake edge. It falls in the cycle after the output register stops holding that rd, i.e. once register_file holds the value.

## Configuration
- WRITEBACK_BYPASS_EN defined:
  - rsN_fwd_valid = rsN_pending.
  - rsN_fwd_data comes from the youngest match, in priority order: newest queue entry (tail−1 backwards), then the output register.
- Undefined:
  - rsN_fwd_valid = 0 and rsN_fwd_data = 0.
  - No match-priority logic is synthesized. Decode must stall on pending.

## Structure
- Package wb_pkg contains:
  - DATA_W and ADDR_W defaults.
  - typedef wb_entry_t {rd, data}.
  - Localparam for the x0 index.
- Sub-module wb_fifo contains:
  - Entry storage, per-entry valid bits, head/tail/count, push/pop, full/empty.
  - It exports the entry array and valid vector for the match logic.
- writeback_queue contains the output register, the arbitration, and the pending/forward compare.

## Test plan
- Reset, then push {rd=5, data=0xA5A5A5A5} at E1:
  - RegWrite=1, rd=5, write_data=0xA5A5A5A5 after E2.
  - RegWrite=0 after E3.
  - rs1=5 gives pending=1 from E1 until E3.
- Hold ext_wr_req high for 6 cycles while pushing rd=1..6:
  - in_ready drops to 0 after the 4th push.
  - On release, rd 1,2,3,4 drain in order on consecutive cycles; no entries are lost.
- Push in_rd=0 with data 0xFFFFFFFF:
  - Handshake completes, count stays 0, and RegWrite never rises.
  - rs1=0 reports pending=0.
- With WRITEBACK_BYPASS_EN, queue rd=7 with 0x11, then rd=7 with 0x22, while ext_wr_req holds the drain; drive rs2=7:
  - rs2_fwd_valid=1 and rs2_fwd_data=0x22.
  - Without the macro: rs2_fwd_valid=0 and rs2_pending=1.
- Fill the queue with 3 entries, then assert rst for one cycle:
  - RegWrite=0 and rd=0 after the edge.
  - Count 0 and all pending flags 0.
  - No queued value is ever written.
- Full queue with simultaneous pop and in_valid:
  - No push is accepted that cycle (in_ready=0).
  - in_ready=1 next cycle and count=DEPTH−1.
